// File: rtl/step_pkg.sv
// ---------------------------------------------------------------------------
// step_pkg: shared types and constants for the step sequencer.
//   - default timing/pattern parameters
//   - arrow bit positions inside a 4-bit mask {U,D,L,R}
//   - FSM state encoding
//   - saturating 8-bit increment helper used by the score/miss counters
// ---------------------------------------------------------------------------
package step_pkg;

    localparam int unsigned DEF_BEAT_CYCLES   = 50_000_000;
    localparam int unsigned DEF_WINDOW_CYCLES = 12_500_000;
    localparam int unsigned DEF_PAT_LEN       = 16;

    localparam int unsigned ARROW_W = 4;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned COUNT_W = 8;
    localparam int unsigned STATE_W = 3;

    // Bit positions of each arrow inside btn / arrow / pat_data
    localparam int unsigned ARROW_U = 3;
    localparam int unsigned ARROW_D = 2;
    localparam int unsigned ARROW_L = 1;
    localparam int unsigned ARROW_R = 0;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_PROMPT = 3'd3,
        ST_DONE   = 3'd4
    } seqStateE;

    // Increment that sticks at all-ones
    function automatic logic [COUNT_W-1:0] satInc(input logic [COUNT_W-1:0] val);
        return (val == {COUNT_W{1'b1}}) ? val : val + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/beat_timer.sv
// ---------------------------------------------------------------------------
// beat_timer: per-beat cycle counter for the step sequencer.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   clear           restart the beat at count 0 (sequencer LOAD)
//   run             advance the count by one (sequencer PROMPT)
//   in_window       registered: current count < WINDOW_CYCLES
//   win_end         registered: current count == WINDOW_CYCLES
//   beat_end        registered: current count == BEAT_CYCLES-1
// The flags are computed from the next count so they line up with the
// count value held in the same cycle.
// ---------------------------------------------------------------------------
module beat_timer
    import step_pkg::*;
#(
    parameter int unsigned BEAT_CYCLES   = DEF_BEAT_CYCLES,
    parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic in_window,
    output logic win_end,
    output logic beat_end
);

    localparam int unsigned CNT_W = $clog2(BEAT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WIN_CNT  = CNT_W'(WINDOW_CYCLES);

    logic [CNT_W-1:0] beatCnt;
    logic [CNT_W-1:0] cntNext;

    // Next count: clear wins, then wrap at the last cycle of the beat
    always_comb begin
        cntNext = beatCnt;
        if (clear) begin
            cntNext = '0;
        end else if (run) begin
            cntNext = (beatCnt == LAST_CNT) ? '0 : beatCnt + CNT_W'(1);
        end
    end

    // Count register and decoded flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beatCnt   <= '0;
            in_window <= 1'b1;
            win_end   <= 1'b0;
            beat_end  <= 1'b0;
        end else begin
            beatCnt   <= cntNext;
            in_window <= (cntNext < WIN_CNT);
            win_end   <= (cntNext == WIN_CNT);
            beat_end  <= (cntNext == LAST_CNT);
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// ---------------------------------------------------------------------------
// step_sequencer: rhythm-game beat sequencer.
// Walks an external pattern ROM one beat at a time, shows the arrow mask of
// each beat, and judges the player's presses inside a hit window.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start            single-cycle request to begin a pattern (ignored while busy)
//   btn[3:0]         press pulses {U,D,L,R}
//   pat_addr[7:0]    registered ROM address
//   pat_data[3:0]    ROM arrow mask, valid one cycle after pat_addr
//   arrow[3:0]       prompt mask currently shown (cleared once judged)
//   hit, miss        single-cycle judgement pulses
//   score, misses    saturating 8-bit counts
//   busy             pattern running
//   done             pattern finished, held until the next start
// A beat is FETCH (address out), LOAD (capture ROM data), then BEAT_CYCLES
// of PROMPT, so every non-final beat lasts BEAT_CYCLES+2 cycles.
// ---------------------------------------------------------------------------
module step_sequencer
    import step_pkg::*;
#(
    parameter int unsigned BEAT_CYCLES   = DEF_BEAT_CYCLES,
    parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int unsigned PAT_LEN       = DEF_PAT_LEN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ARROW_W-1:0] btn,
    output logic [ADDR_W-1:0]  pat_addr,
    input  logic [ARROW_W-1:0] pat_data,
    output logic [ARROW_W-1:0] arrow,
    output logic               hit,
    output logic               miss,
    output logic [COUNT_W-1:0] score,
    output logic [COUNT_W-1:0] misses,
    output logic               busy,
    output logic               done
);

    localparam logic [STATE_W-1:0] S_IDLE   = STATE_W'(ST_IDLE);
    localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(ST_FETCH);
    localparam logic [STATE_W-1:0] S_LOAD   = STATE_W'(ST_LOAD);
    localparam logic [STATE_W-1:0] S_PROMPT = STATE_W'(ST_PROMPT);
    localparam logic [STATE_W-1:0] S_DONE   = STATE_W'(ST_DONE);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PAT_LEN - 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] stateNext;
    logic [ADDR_W-1:0]  idx;
    logic [ADDR_W-1:0]  idxNext;
    logic [ADDR_W-1:0]  patAddrNext;
    logic               judged;
    logic               judgedNext;
    logic [ARROW_W-1:0] arrowNext;
    logic [COUNT_W-1:0] scoreNext;
    logic [COUNT_W-1:0] missesNext;
    logic               hitNext;
    logic               missNext;
    logic               busyNext;
    logic               doneNext;

    logic               cntClear;
    logic               cntRun;
    logic               inWindow;
    logic               winEnd;
    logic               beatEnd;

    logic               judgeOpen;
    logic               pressed;

    beat_timer #(
        .BEAT_CYCLES   (BEAT_CYCLES),
        .WINDOW_CYCLES (WINDOW_CYCLES)
    ) u_beat_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (cntClear),
        .run       (cntRun),
        .in_window (inWindow),
        .win_end   (winEnd),
        .beat_end  (beatEnd)
    );

    // Next-state and next-output logic
    always_comb begin
        stateNext   = state;
        idxNext     = idx;
        patAddrNext = pat_addr;
        judgedNext  = judged;
        arrowNext   = arrow;
        scoreNext   = score;
        missesNext  = misses;
        hitNext     = 1'b0;
        missNext    = 1'b0;
        doneNext    = done;
        cntClear    = 1'b0;
        cntRun      = 1'b0;

        // A cleared arrow also covers rest beats and already-judged beats
        judgeOpen = inWindow && (arrow != '0) && !judged;
        pressed   = (btn != '0);

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    stateNext   = S_FETCH;
                    idxNext     = '0;
                    patAddrNext = '0;
                    scoreNext   = '0;
                    missesNext  = '0;
                    doneNext    = 1'b0;
                end
            end

            S_FETCH: begin
                stateNext = S_LOAD;
            end

            S_LOAD: begin
                arrowNext  = pat_data;
                judgedNext = 1'b0;
                cntClear   = 1'b1;
                stateNext  = S_PROMPT;
            end

            S_PROMPT: begin
                cntRun = 1'b1;

                // Exact chord is a hit; any other nonzero press is a miss.
                // A press on the timeout cycle falls outside the window.
                if (judgeOpen && pressed) begin
                    if (btn == arrow) begin
                        hitNext   = 1'b1;
                        scoreNext = satInc(score);
                    end else begin
                        missNext   = 1'b1;
                        missesNext = satInc(misses);
                    end
                    judgedNext = 1'b1;
                    arrowNext  = '0;
                end else if (winEnd && !judged && (arrow != '0)) begin
                    missNext   = 1'b1;
                    missesNext = satInc(misses);
                    judgedNext = 1'b1;
                    arrowNext  = '0;
                end

                if (beatEnd) begin
                    if (idx == LAST_IDX) begin
                        stateNext = S_DONE;
                        doneNext  = 1'b1;
                    end else begin
                        idxNext     = idx + ADDR_W'(1);
                        patAddrNext = idx + ADDR_W'(1);
                        stateNext   = S_FETCH;
                    end
                end
            end

            default: begin
                stateNext = S_IDLE;
            end
        endcase

        busyNext = (stateNext == S_FETCH) || (stateNext == S_LOAD) ||
                   (stateNext == S_PROMPT);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            judged   <= 1'b0;
            pat_addr <= '0;
            arrow    <= '0;
            score    <= '0;
            misses   <= '0;
            hit      <= 1'b0;
            miss     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= stateNext;
            idx      <= idxNext;
            judged   <= judgedNext;
            pat_addr <= patAddrNext;
            arrow    <= arrowNext;
            score    <= scoreNext;
            misses   <= missesNext;
            hit      <= hitNext;
            miss     <= missNext;
            busy     <= busyNext;
            done     <= doneNext;
        end
    end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameter BEAT_CYCLES, default 50_000_000: clk cycles per beat; legal values are >= 4.
REQ-002 Parameter WINDOW_CYCLES, default 12_500_000: hit window length from beat start; legal values are 1 .. BEAT_CYCLES-2.
REQ-003 Parameter PAT_LEN, default 16: beats per pattern; legal values are 2 .. 256.
REQ-004 Port clk, input, 1: single system clock; all logic is on the rising edge.
REQ-005 Port rst_n, input, 1: reset is synchronous and active-low.
REQ-006 Port start, input, 1: single-cycle request to begin a pattern.
REQ-007 Port btn, input, 4: debounced single-cycle press pulses, bits {U,D,L,R} = [3:0].
REQ-008 Port pat_addr, output, 8: pattern ROM address, registered.
REQ-009 Port pat_data, input, 4: ROM arrow mask, valid 1 cycle after pat_addr; 0 = rest beat.
REQ-010 Port arrow, output, 4: current prompt mask shown to the player.
REQ-011 Port hit and miss, outputs, 1 each: single-cycle judgement pulses.
REQ-012 Port score and misses, outputs, 8 each: saturating hit and miss counts.
REQ-013 Port busy and done, outputs, 1 each: busy = pattern running; done = pattern finished, held.

Function
REQ-014 FSM states: IDLE, FETCH, LOAD, PROMPT, DONE.
REQ-015 IDLE or DONE with start=1: clear idx, score and misses; clear done; go to FETCH.
REQ-016 FETCH drives pat_addr=idx for one cycle, then goes to LOAD.
REQ-017 LOAD registers pat_data into arrow, clears beat_cnt and judged, then goes to PROMPT.
REQ-018 Timing: start sampled in cycle N gives pat_addr valid at N+1 and arrow valid at N+3 (first PROMPT cycle, beat_cnt=0).
REQ-019 PROMPT increments beat_cnt by 1 every cycle.
REQ-020 Window: judging is open while beat_cnt < WINDOW_CYCLES, arrow != 0 and judged=0.
REQ-021 Nonzero btn inside the window with btn == arrow exactly: hit=1 next cycle, score+1 (saturate at 255).
REQ-022 Nonzero btn inside the window with btn != arrow, including partial chords: miss=1 next cycle, misses+1 (saturate at 255).
REQ-023 After any judgement: set judged=1, clear arrow to 0; later presses in the same beat are ignored.
REQ-024 Timeout: at beat_cnt == WINDOW_CYCLES with judged=0 and arrow != 0, pulse miss, increment misses, clear arrow.
REQ-025 A press on the timeout cycle is ignored; exactly one miss pulse is produced.
REQ-026 Rest beats (arrow=0) never produce hit or miss; btn is ignored.
REQ-027 Btn presses outside PROMPT are ignored.
REQ-028 Beat end, beat_cnt == BEAT_CYCLES-1: if idx == PAT_LEN-1, go to DONE and set done=1; otherwise increment idx and go to FETCH.
REQ-029 Beat period: a non-final beat occupies exactly BEAT_CYCLES+2 cycles (FETCH + LOAD + PROMPT).
REQ-030 busy=1 in FETCH, LOAD and PROMPT; busy=0 otherwise.
REQ-031 start while busy is ignored.
REQ-032 At most one of hit or miss is asserted in any cycle.

Reset
REQ-033 When rst_n=0 at a clock edge, the next state is: state=IDLE; idx, beat_cnt, judged, pat_addr, arrow, score and misses all 0; hit, miss, busy and done all 0.
REQ-034 Reset mid-pattern aborts the pattern with no judgement pulse; reset has priority over start and btn.

Structure
REQ-035 Package step_pkg holds the FSM state enum, the arrow bit-index constants (U=3, D=2, L=1, R=0) and the default parameter values.
REQ-036 Sub-module beat_timer owns beat_cnt and outputs in_window, win_end and beat_end; the sequencer instantiates it once.
REQ-037 The pattern ROM is external and must not be part of this block.

Verification (BEAT_CYCLES=8, WINDOW_CYCLES=4, PAT_LEN=4, ROM={4'b1000, 4'b0000, 4'b0011, 4'b0100})
REQ-038 Scenario: start at cycle 0 -> pat_addr=0 at cycle 1, arrow=4'b1000 at cycle 3, busy=1.
REQ-039 Scenario: btn=4'b1000 at beat_cnt=2 of beat 0 -> hit pulse, score=1, arrow=0; a second press in the same beat does nothing.
REQ-040 Scenario: beat 2 btn=4'b0001 -> miss, misses=1; beat 3 with no press -> miss at beat_cnt=4, misses=2.
REQ-041 Scenario: btn=4'b0100 on the timeout cycle of beat 3 -> exactly one miss pulse; done=1 after beat 3; the rest beat produces no pulses.
REQ-042 Scenario: rst_n=0 during beat 2 -> next cycle IDLE with all outputs 0; a following start runs the full pattern again.
REQ-043 Scenario: 300 forced hits with PAT_LEN=256 looped -> score saturates at 255; start during busy is ignored.
